// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder cell, shared by every bit position of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH cycles, with
// ready/valid handshakes on the operand and result sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, shb_q, res_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             cell_sum, cell_carry;

  fa_cell u_fa_cell (
    .a     (sha_q[0]),
    .b     (shb_q[0]),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun) || (state_q == StDone);
    sum       = res_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sha_q   <= a;
            shb_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          res_q   <= {cell_sum, res_q[WIDTH-1:1]};
          carry_q <= cell_carry;
          cnt_q   <= cnt_q + CntW'(1);
          // On the MSB, carry_q is the carry into bit WIDTH-1.
          if (cnt_q == CntLast) begin
            cout_q <= cell_carry;
            ovf_q  <= carry_q ^ cell_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It sequences one 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- It has a ready/valid handshake on both the operand side and the result side.
- It sits between an operand producer and a result consumer in area-constrained arithmetic paths.
- It trades latency for a single adder cell instead of a ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on a, b, cin are valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid (DONE only)
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  a + b + cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow (carry into MSB XOR cout)
- busy  output  1  high in RUN and DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk; asynchronous reset is not used.
- Reset values:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0; internal shift registers, carry flop and counter are cleared.
- Reset mid-operation (RUN or DONE) aborts immediately. The in-flight result is discarded and out_valid is never asserted for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load a into shA and b into shB, set carry<=cin, set cnt<=0, move to RUN.
- RUN, one bit per cycle:
  - Cell inputs are shA[0], shB[0], carry.
  - shA and shB shift right.
  - The result shift register shifts right, with the cell sum entering at bit WIDTH-1.
  - carry<=cell carry-out; cnt<=cnt+1.
  - When cnt==WIDTH-1:
    - Capture ovf <= carry_in_this_cycle XOR cell carry-out.
    - Capture cout <= cell carry-out.
    - Move to DONE.
  - in_ready=0. in_valid is ignored and the operands are not re-sampled.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On an edge with out_ready=1, move to IDLE. out_valid drops the next cycle, and sum/cout/ovf keep their values until the next transfer completes.
  - Backpressure: DONE holds indefinitely while out_ready=0.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
  - Throughput is one operation per WIDTH+2 cycles minimum, since there is no accept while in DONE.
- out_ready asserted before out_valid has no effect.
- in_valid held high continuously: the next operand is accepted on the first IDLE edge after the DONE handshake.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - cout is the unsigned carry.
  - ovf is valid for signed operands; it is always computed, whatever the interpretation.
- Counter width: $clog2(WIDTH). No wrap-around is possible because the counter resets on every accept.

Decomposition:
- Package serial_add_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter-width helper function.
- Sub-module fa_cell:
  - Purely combinational 1-bit full adder with inputs a, b, c and outputs sum, carry.
  - Instantiated once. The controller contains no other adder.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0 accepted -> out_valid exactly 8 edges later; sum=8'h7F, cout=0, ovf=0.
- Carry and overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
  - a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- Carry-in and backpressure: a=8'hFF, b=8'hFF, cin=1 with out_ready=0 for 5 cycles -> sum=8'hFF, cout=1 held stable with out_valid=1 throughout. Release out_ready -> IDLE next cycle.
- Ignore and back-to-back: change a/b with in_valid=1 during RUN -> result unaffected. With in_valid held high, the second operand pair is accepted on the first IDLE edge and its result is correct.
- Reset mid-RUN: assert rst at bit 4 -> IDLE next edge, out_valid never asserted. The next operation (a=8'h10, b=8'h20) gives sum=8'h30.
